addround_stream: RTL and testbench

Parametrised, streaming AddRoundKey stage for the AES datapath. It accepts the 128-bit cipher state as a sequence of `LANES`-byte beats and XORs each beat with the matching round-subkey bytes. Valid/ready handshakes sit on both sides. It tracks the beat position within the block and the round number, so downstream SubBytes/ShiftRows/MixColumns stages and the key scheduler can align without their own counters. It replaces the fixed 8-bit combinational add-round unit.

---
 rtl/addround_stream.sv | 127 ++++++++++++
 tb/tb_addround_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/addround_stream.sv
// Streaming AES AddRoundKey stage with beat/round tracking and valid/ready flow.
// Define ADDROUND_OUTREG_EN to add a second output register stage (2-cycle latency).
module addround_stream #(
  parameter int LANES   = 1,
  parameter int NROUNDS = 10,
  localparam int BEATS  = 16 / LANES,
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              around_enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*LANES-1:0] olddata,
  input  logic [8*LANES-1:0] subkey,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*LANES-1:0] newdata,
  output logic [BW-1:0]     beat_idx,
  output logic              block_last,
  output logic [3:0]        round,
  output logic              round_last
);

  localparam int W = 8 * LANES;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [3:0]    LAST_ROUND = 4'(NROUNDS);

  logic [BW-1:0] in_beat;
  logic [3:0]    in_round;
  logic          accept;
  logic          wrap;

  assign accept = in_valid && in_ready;
  assign wrap   = (in_beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_beat  <= '0;
      in_round <= '0;
    end else if (accept) begin
      in_beat <= wrap ? '0 : in_beat + 1'b1;
      if (wrap)
        in_round <= (in_round == LAST_ROUND) ? '0 : in_round + 1'b1;
    end
  end

  // XOR stage: result and sideband travel together
  logic          s1_full;
  logic [W-1:0]  s1_data;
  logic [BW-1:0] s1_beat;
  logic          s1_blast;
  logic [3:0]    s1_round;
  logic          s1_rlast;
  logic          s1_dn;

  assign in_ready = !s1_full || s1_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full  <= 1'b0;
      s1_data  <= '0;
      s1_beat  <= '0;
      s1_blast <= 1'b0;
      s1_round <= '0;
      s1_rlast <= 1'b0;
    end else if (accept) begin
      s1_full  <= 1'b1;
      s1_data  <= olddata ^ ({W{around_enable}} & subkey);
      s1_beat  <= in_beat;
      s1_blast <= wrap;
      s1_round <= in_round;
      s1_rlast <= (in_round == LAST_ROUND);
    end else if (s1_dn) begin
      s1_full <= 1'b0;
    end
  end

`ifdef ADDROUND_OUTREG_EN
  logic          s2_full;
  logic [W-1:0]  s2_data;
  logic [BW-1:0] s2_beat;
  logic          s2_blast;
  logic [3:0]    s2_round;
  logic          s2_rlast;
  logic          s2_load;

  assign s1_dn   = !s2_full || out_ready;
  assign s2_load = s1_full && s1_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_full  <= 1'b0;
      s2_data  <= '0;
      s2_beat  <= '0;
      s2_blast <= 1'b0;
      s2_round <= '0;
      s2_rlast <= 1'b0;
    end else if (s2_load) begin
      s2_full  <= 1'b1;
      s2_data  <= s1_data;
      s2_beat  <= s1_beat;
      s2_blast <= s1_blast;
      s2_round <= s1_round;
      s2_rlast <= s1_rlast;
    end else if (out_ready) begin
      s2_full <= 1'b0;
    end
  end

  assign out_valid  = s2_full;
  assign newdata    = s2_data;
  assign beat_idx   = s2_beat;
  assign block_last = s2_blast;
  assign round      = s2_round;
  assign round_last = s2_rlast;
`else
  assign s1_dn      = out_ready;
  assign out_valid  = s1_full;
  assign newdata    = s1_data;
  assign beat_idx   = s1_beat;
  assign block_last = s1_blast;
  assign round      = s1_round;
  assign round_last = s1_rlast;
`endif

endmodule

// File: tb/tb_addround_stream.sv
// Self-checking bench for addround_stream: LANES=1 scoreboard run plus LANES=4 directed checks.
module tb_addround_stream;

`ifdef ADDROUND_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       around_enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] olddata = '0;
  logic [7:0] subkey = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] newdata;
  logic [3:0] beat_idx;
  logic       block_last;
  logic [3:0] round;
  logic       round_last;

  logic        around_enable4 = 1'b0;
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [31:0] olddata4 = '0;
  logic [31:0] subkey4 = '0;
  logic        out_valid4;
  logic        out_ready4 = 1'b0;
  logic [31:0] newdata4;
  logic [1:0]  beat_idx4;
  logic        block_last4;
  logic [3:0]  round4;
  logic        round_last4;

  addround_stream #(.LANES(1), .NROUNDS(10)) dut (
    .clk(clk), .rst(rst), .around_enable(around_enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .olddata(olddata), .subkey(subkey),
    .out_valid(out_valid), .out_ready(out_ready),
    .newdata(newdata), .beat_idx(beat_idx), .block_last(block_last),
    .round(round), .round_last(round_last)
  );

  addround_stream #(.LANES(4), .NROUNDS(10)) dut4 (
    .clk(clk), .rst(rst), .around_enable(around_enable4),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .olddata(olddata4), .subkey(subkey4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .newdata(newdata4), .beat_idx(beat_idx4), .block_last(block_last4),
    .round(round4), .round_last(round_last4)
  );

  typedef struct {
    logic [7:0] d;
    int         n;
    int         t;
  } exp_t;

  exp_t q[$];
  int   n_in = 0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle on the LANES=1 DUT, entered and left at a falling edge.
  task automatic step(input logic v, input logic [7:0] d,
                      input logic [7:0] k, input logic en,
                      input logic ordy);
    exp_t e;
    int   bi;
    int   rn;
    in_valid      = v;
    olddata       = d;
    subkey        = k;
    around_enable = en;
    out_ready     = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'((q.size() < LAT) || ordy));
    check("out_valid", 32'(out_valid),
          32'(q.size() > 0 && (cyc - q[0].t) >= LAT));
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e  = q.pop_front();
        bi = e.n % 16;
        rn = (e.n / 16) % 11;
        check("sb_data", 32'(newdata), 32'(e.d));
        check("sb_beat", 32'(beat_idx), 32'(bi));
        check("sb_round", 32'(round), 32'(rn));
        check("sb_blast", 32'(block_last), 32'(bi == 15));
        check("sb_rlast", 32'(round_last), 32'(rn == 10));
      end
    end
    if (in_valid && in_ready) begin
      e.d = en ? (d ^ k) : d;
      e.n = n_in;
      e.t = cyc;
      q.push_back(e);
      n_in++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    out_ready = 1'b0;
    out_ready4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    n_in = 0;
    cyc++;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_newdata", 32'(newdata), 32'd0);
    check("rst_beat", 32'(beat_idx), 32'd0);
    check("rst_blast", 32'(block_last), 32'd0);
    check("rst_round", 32'(round), 32'd0);
    check("rst_rlast", 32'(round_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid4", 32'(out_valid4), 32'd0);
    check("rst_newdata4", newdata4, 32'd0);
  endtask

  task automatic idle(input int cnt, input logic ordy);
    for (int i = 0; i < cnt; i++) step(1'b0, 8'h00, 8'h00, 1'b0, ordy);
  endtask

  initial begin
    logic [7:0] hold;
    int         k;
    @(negedge clk);
    do_reset();

    // AA ^ CC
    step(1'b1, 8'hAA, 8'hCC, 1'b1, 1'b1);
    idle(LAT - 1, 1'b0);
    check("xor_valid", 32'(out_valid), 32'd1);
    check("xor_data", 32'(newdata), 32'h66);
    check("xor_beat", 32'(beat_idx), 32'd0);
    check("xor_round", 32'(round), 32'd0);
    idle(1, 1'b1);

    // pass-through then XOR of the same beat
    step(1'b1, 8'hC3, 8'h0F, 1'b0, 1'b1);
    idle(LAT - 1, 1'b0);
    check("pass_data", 32'(newdata), 32'hC3);
    step(1'b1, 8'hC3, 8'h0F, 1'b1, 1'b1);
    idle(LAT - 1, 1'b0);
    check("en_data", 32'(newdata), 32'hCC);
    idle(LAT + 1, 1'b1);

    // backpressure
    for (int i = 0; i < LAT; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    hold = newdata;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      check("bp_hold", 32'(newdata), 32'(hold));
    end
    idle(LAT + 3, 1'b1);

    // round wrap over one full AES-128 block and one more beat
    do_reset();
    for (int i = 0; i < 177; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    idle(LAT + 1, 1'b1);

    // reset mid-block
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'($urandom | 1), 8'h00, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 8'h5A, 8'hA5, 1'b1, 1'b1);
    idle(LAT - 1, 1'b0);
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_beat", 32'(beat_idx), 32'd0);
    check("mid_round", 32'(round), 32'd0);
    check("mid_data", 32'(newdata), 32'hFF);
    idle(LAT + 1, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0));
    idle(LAT + 3, 1'b1);
    check("drained", 32'(q.size()), 32'd0);

    // LANES=4
    do_reset();
    for (int c = 0; c < 5 + LAT; c++) begin
      in_valid4      = (c < 5);
      olddata4       = 32'h00112233;
      subkey4        = 32'hFFFFFFFF;
      around_enable4 = 1'b1;
      out_ready4     = 1'b1;
      #1;
      if (c >= LAT) begin
        k = c - LAT;
        check("l4_valid", 32'(out_valid4), 32'd1);
        check("l4_data", newdata4, 32'hFFEEDDCC);
        check("l4_beat", 32'(beat_idx4), 32'(k % 4));
        check("l4_blast", 32'(block_last4), 32'(k == 3));
        check("l4_round", 32'(round4), 32'(k / 4));
      end
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
